// File: rtl/lcd_capture.sv
// Receiver for the raw 4-bit STN LCD bus: synchronises data/flm/lp/dclk/m into clk,
// rebuilds the framebuffer write stream and flags line-length, frame-height and M faults.
`timescale 1ns/1ps
module lcd_capture #(
    parameter int H_RES  = 320,
    parameter int V_RES  = 240,
    parameter int ADDR_W = 15
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [3:0]        data,
    input  logic              flm,
    input  logic              lp,
    input  logic              dclk,
    input  logic              m,
    output logic              pix_we,
    output logic [ADDR_W-1:0] pix_addr,
    output logic [3:0]        pix_data,
    output logic              frame_done,
    output logic [9:0]        row,
    output logic              len_err,
    output logic              frm_err,
    output logic              m_err
);

    // state  | meaning
    // IDLE   | waiting for flm+lp, bus activity discarded
    // ACTIVE | capturing lines of the current frame

    localparam int NIB   = H_RES / 4;
    localparam int COL_W = $clog2(NIB + 1);
    localparam logic [COL_W-1:0] NIB_C  = COL_W'(NIB);
    localparam logic [9:0]       VRES_C = 10'(V_RES);

    typedef enum logic {IDLE, ACTIVE} state_t;

    state_t state_q, state_n;

    // bus packing: [7:4] data, [3] flm, [2] lp, [1] dclk, [0] m
    logic [7:0] sync1, sync2;
    logic       lp_d3, dclk_d3;

    logic [3:0] data_s;
    logic       flm_s, lp_s, dclk_s, m_s;
    logic       dclk_fall, lp_rise;

    logic [COL_W-1:0]  col_q, col_n;
    logic [9:0]        row_q, row_n;
    logic              ovr_q, ovr_n;
    logic              bad_q, bad_n;
    logic              mref_q, mref_n;
    logic              we_q, we_n;
    logic [ADDR_W-1:0] addr_q, addr_n;
    logic [3:0]        pdat_q, pdat_n;
    logic              done_q, done_n;
    logic              len_q, len_n;
    logic              frm_q, frm_n;
    logic              merr_q, merr_n;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1   <= '0;
            sync2   <= '0;
            lp_d3   <= 1'b0;
            dclk_d3 <= 1'b0;
        end else begin
            sync1   <= {data, flm, lp, dclk, m};
            sync2   <= sync1;
            lp_d3   <= sync2[2];
            dclk_d3 <= sync2[1];
        end
    end

    assign data_s    = sync2[7:4];
    assign flm_s     = sync2[3];
    assign lp_s      = sync2[2];
    assign dclk_s    = sync2[1];
    assign m_s       = sync2[0];
    assign dclk_fall = dclk_d3 & ~dclk_s;
    assign lp_rise   = lp_s & ~lp_d3;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_n;
    end

    always_comb begin
        state_n = state_q;
        if (state_q == IDLE && lp_rise && flm_s)
            state_n = ACTIVE;
    end

    always_comb begin
        col_n  = col_q;
        row_n  = row_q;
        ovr_n  = ovr_q;
        bad_n  = bad_q;
        mref_n = mref_q;
        we_n   = 1'b0;
        addr_n = addr_q;
        pdat_n = pdat_q;
        done_n = 1'b0;
        len_n  = len_q;
        frm_n  = frm_q;
        merr_n = merr_q;
        case (state_q)
            IDLE: begin
                if (lp_rise && flm_s) begin
                    col_n  = '0;
                    row_n  = '0;
                    ovr_n  = 1'b0;
                    bad_n  = 1'b0;
                    mref_n = m_s;
                end
            end
            ACTIVE: begin
                // a nibble landing on the same cycle as lp belongs to the line being closed
                if (dclk_fall) begin
                    if (col_q < NIB_C) begin
                        if (row_q < VRES_C) begin
                            we_n   = 1'b1;
                            addr_n = ADDR_W'(row_q) * ADDR_W'(NIB) + ADDR_W'(col_q);
                            pdat_n = data_s;
                        end
                        col_n = col_q + COL_W'(1);
                    end else begin
                        ovr_n = 1'b1;
                    end
                end
                if (lp_rise) begin
                    if (col_n != NIB_C || ovr_n) begin
                        len_n = 1'b1;
                        bad_n = 1'b1;
                    end
                    col_n = '0;
                    ovr_n = 1'b0;
                    row_n = (row_q >= VRES_C) ? VRES_C : row_q + 10'd1;
                    if (flm_s) begin
                        if ((row_q + 10'd1) != VRES_C) frm_n  = 1'b1;
                        else if (!bad_n)               done_n = 1'b1;
                        row_n  = '0;
                        bad_n  = 1'b0;
                        if (m_s == mref_q) merr_n = 1'b1;
                        mref_n = m_s;
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_q  <= '0;
            row_q  <= '0;
            ovr_q  <= 1'b0;
            bad_q  <= 1'b0;
            mref_q <= 1'b0;
            we_q   <= 1'b0;
            addr_q <= '0;
            pdat_q <= '0;
            done_q <= 1'b0;
            len_q  <= 1'b0;
            frm_q  <= 1'b0;
            merr_q <= 1'b0;
        end else begin
            col_q  <= col_n;
            row_q  <= row_n;
            ovr_q  <= ovr_n;
            bad_q  <= bad_n;
            mref_q <= mref_n;
            we_q   <= we_n;
            addr_q <= addr_n;
            pdat_q <= pdat_n;
            done_q <= done_n;
            len_q  <= len_n;
            frm_q  <= frm_n;
            merr_q <= merr_n;
        end
    end

    assign pix_we     = we_q;
    assign pix_addr   = addr_q;
    assign pix_data   = pdat_q;
    assign frame_done = done_q;
    assign row        = row_q;
    assign len_err    = len_q;
    assign frm_err    = frm_q;
    assign m_err      = merr_q;

endmodule

// File: tb/tb_lcd_capture.sv
// Randomised bench for lcd_capture: drives the LCD bus line by line and checks the write
// stream, row index, frame_done and sticky flags against a line-level reference model.
`timescale 1ns/1ps
module tb_lcd_capture;
    localparam int H_RES  = 8;
    localparam int V_RES  = 4;
    localparam int ADDR_W = 6;
    localparam int NIB    = H_RES / 4;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [3:0]        data = '0;
    logic              flm = 1'b0, lp = 1'b0, dclk = 1'b0, m = 1'b0;
    logic              pix_we, frame_done, len_err, frm_err, m_err;
    logic [ADDR_W-1:0] pix_addr;
    logic [3:0]        pix_data;
    logic [9:0]        row;

    lcd_capture #(.H_RES(H_RES), .V_RES(V_RES), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst_n(rst_n), .data(data), .flm(flm), .lp(lp), .dclk(dclk), .m(m),
        .pix_we(pix_we), .pix_addr(pix_addr), .pix_data(pix_data), .frame_done(frame_done),
        .row(row), .len_err(len_err), .frm_err(frm_err), .m_err(m_err)
    );

    always #10 clk = ~clk;

    int  checks = 0, failures = 0;
    int  act_addr[$], act_data[$], exp_addr[$], exp_data[$];
    int  wr_cur = 0;
    int  done_cnt = 0, lat_bad = 0;
    time last_fall = 0;

    // reference model state
    bit m_active, m_bad, m_ref, e_len, e_frm, e_merr, hold_m;
    int m_row, e_done = 0;

    always @(negedge clk) begin
        if (pix_we) begin
            act_addr.push_back(int'(pix_addr));
            act_data.push_back(int'(pix_data));
            if (($time - last_fall) != 67) lat_bad++;
        end
        if (frame_done) done_cnt++;
    end

    task automatic chk(input string tag, input int obs, input int expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    task automatic model_reset();
        m_active = 0; m_row = 0; m_bad = 0; m_ref = 0;
        e_len = 0; e_frm = 0; e_merr = 0;
    endtask

    task automatic model_line(input int n, input bit f, input int ds[16]);
        if (!m_active) begin
            if (f) begin
                m_active = 1; m_row = 0; m_bad = 0; m_ref = m;
            end
        end else begin
            for (int c = 0; c < n; c++)
                if (c < NIB && m_row < V_RES) begin
                    exp_addr.push_back(m_row * NIB + c);
                    exp_data.push_back(ds[c]);
                end
            if (n != NIB) begin e_len = 1; m_bad = 1; end
            if (f) begin
                if (m_row + 1 != V_RES) e_frm = 1;
                else if (!m_bad) e_done++;
                if (m == m_ref) e_merr = 1;
                m_ref = m; m_row = 0; m_bad = 0;
            end else if (m_row < V_RES) begin
                m_row++;
            end
        end
    endtask

    task automatic nibble(input logic [3:0] d, input bit with_lp, input bit f);
        @(posedge clk); #3;
        data = d; dclk = 1'b1;
        if (with_lp) flm = f;
        #100;
        dclk = 1'b0; last_fall = $time;
        if (with_lp) lp = 1'b1;
        #100;
        if (with_lp) begin lp = 1'b0; #20; flm = 1'b0; end
    endtask

    task automatic lp_pulse(input bit f);
        @(posedge clk); #3;
        flm = f; #40; lp = 1'b1; #100; lp = 1'b0; #40; flm = 1'b0;
    endtask

    task automatic send_line(input int n, input bit f, input bit simult);
        int ds[16];
        if (f && !hold_m) m = ~m;
        for (int c = 0; c < n; c++) begin
            ds[c] = int'($urandom_range(0, 15));
            nibble(4'(ds[c]), simult && c == n - 1, f);
        end
        if (!(simult && n > 0)) lp_pulse(f);
        model_line(n, f, ds);
        chk("row", int'(row), m_row);
    endtask

    task automatic send_frame(input int bad_row, input int bad_len, input bit simult);
        for (int r = 0; r < V_RES; r++)
            send_line((r == bad_row) ? bad_len : NIB, r == V_RES - 1, simult);
    endtask

    task automatic check_writes();
        chk("wr_count", act_addr.size(), exp_addr.size());
        for (int i = wr_cur; i < exp_addr.size() && i < act_addr.size(); i++) begin
            chk("wr_addr", act_addr[i], exp_addr[i]);
            chk("wr_data", act_data[i], exp_data[i]);
        end
        wr_cur = (act_addr.size() > exp_addr.size()) ? act_addr.size() : exp_addr.size();
        while (act_addr.size() < wr_cur) begin act_addr.push_back(-1); act_data.push_back(-1); end
        while (exp_addr.size() < wr_cur) begin exp_addr.push_back(-2); exp_data.push_back(-2); end
    endtask

    task automatic check_flags();
        chk("len_err", int'(len_err), int'(e_len));
        chk("frm_err", int'(frm_err), int'(e_frm));
        chk("m_err", int'(m_err), int'(e_merr));
        chk("frame_done_count", done_cnt, e_done);
    endtask

    task automatic apply_reset();
        data = '0; flm = 0; lp = 0; dclk = 0;
        rst_n = 1'b0; #53; rst_n = 1'b1;
        model_reset();
        #40;
        chk("rst_row", int'(row), 0);
        chk("rst_we", int'(pix_we), 0);
        check_flags();
    endtask

    initial begin
        hold_m = 0;
        model_reset();
        apply_reset();
        chk("rst_addr", int'(pix_addr), 0);
        chk("rst_data", int'(pix_data), 0);

        // activity before the first flm is ignored
        send_line(NIB, 0, 0);
        send_line(3, 0, 0);
        check_writes();

        // two clean frames, then one with nibble and lp coinciding
        send_line(NIB, 1, 0);
        send_frame(-1, 0, 0);
        send_frame(-1, 0, 0);
        check_writes();
        check_flags();
        send_frame(-1, 0, 1);
        check_writes();
        check_flags();

        // short line spoils a frame, next frame is good again
        send_frame(1, 1, 0);
        send_frame(-1, 0, 0);
        check_writes();
        check_flags();

        // overlong line drops the extra nibble
        send_frame(2, NIB + 1, 0);
        check_writes();
        check_flags();

        // frame height violations: short frame, then a tall frame with row saturation
        apply_reset();
        send_line(NIB, 1, 0);
        for (int r = 0; r < 3; r++) send_line(NIB, r == 2, 0);
        check_flags();
        for (int r = 0; r < 6; r++) send_line(NIB, r == 5, 0);
        check_writes();
        check_flags();

        // m not toggling across frame starts
        apply_reset();
        send_line(NIB, 1, 0);
        hold_m = 1;
        send_frame(-1, 0, 0);
        hold_m = 0;
        check_writes();
        check_flags();

        // reset in the middle of row 2
        send_frame(-1, 0, 0);
        send_line(NIB, 0, 0);
        send_line(NIB, 0, 0);
        @(posedge clk); #3;
        data = 4'h5; dclk = 1'b1; #40;
        rst_n = 1'b0; #1;
        chk("midrst_we", int'(pix_we), 0);
        chk("midrst_addr", int'(pix_addr), 0);
        chk("midrst_data", int'(pix_data), 0);
        chk("midrst_row", int'(row), 0);
        chk("midrst_done", int'(frame_done), 0);
        chk("midrst_merr", int'(m_err), 0);
        model_reset();
        #59; dclk = 1'b0; #60; rst_n = 1'b1; #40;
        send_line(NIB, 0, 0);
        send_line(NIB, 0, 0);
        check_writes();
        send_line(NIB, 1, 0);
        send_frame(-1, 0, 0);
        check_writes();
        check_flags();

        chk("pix_we_latency_errors", lat_bad, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end
endmodule
